// File: rtl/load_store_unit.sv
// Data-memory load/store unit: runs one req/gnt/rvalid bus transaction per access,
// steering byte lanes, extending load data, checking alignment and timing out stuck accesses.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] StoreData,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] LoadData,
  output logic        AlignErr,
  output logic        BusError,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] cnt_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [3:0]  mem_be_r;
  logic [31:0] mem_wdata_r;
  logic        done_r;
  logic        align_err_r;
  logic        bus_err_r;
  logic [31:0] load_data_r;
  logic        req_s;
  logic        legal_s;
  logic        accept_s;
  logic        timeout_s;
  logic        fault_s;
  logic        bus_err_s;
  logic        rd_done_s;

  function automatic logic legal_access(input logic [2:0] f3, input logic we,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = (off[0] == 1'b0);
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = !we;
      3'b101:  ok = !we && (off[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic we,
                                              input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    if (we) begin
      case (f3[1:0])
        2'b00:   be = 4'b0001 << off;
        2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend by access type.
  function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] v;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  v = {{24{sh[7]}}, sh[7:0]};
      3'b001:  v = {{16{sh[15]}}, sh[15:0]};
      3'b100:  v = {24'h000000, sh[7:0]};
      3'b101:  v = {16'h0000, sh[15:0]};
      default: v = rdata;
    endcase
    return v;
  endfunction

  assign req_s     = MemRead | MemWrite;
  assign legal_s   = legal_access(funct3, MemWrite, ALUResult[1:0]);
  assign accept_s  = (state_r == IDLE) && req_s && legal_s;
  assign timeout_s = (({1'b0, cnt_r} + 17'd1) == 17'(TIMEOUT_CYCLES));

  // Stall is gated by rst_n so it drops the instant reset is asserted.
  assign Stall     = rst_n & (((state_r == IDLE) & req_s) | (state_r == REQ) | (state_r == WAIT));
  assign Done      = done_r;
  assign AlignErr  = align_err_r;
  assign BusError  = bus_err_r;
  assign LoadData  = load_data_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_be    = mem_be_r;
  assign mem_wdata = mem_wdata_r;

  // Next-state logic; a completing bus event beats the timeout in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    fault_s     = 1'b0;
    bus_err_s   = 1'b0;
    rd_done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s && legal_s) begin
          state_nxt_s = REQ;
        end else if (req_s) begin
          state_nxt_s = DONE;
          fault_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt && mem_we_r) begin
          state_nxt_s = DONE;
        end else if (timeout_s) begin
          state_nxt_s = DONE;
          bus_err_s   = 1'b1;
        end else if (mem_gnt) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nxt_s = DONE;
          rd_done_s   = 1'b1;
        end else if (timeout_s) begin
          state_nxt_s = DONE;
          bus_err_s   = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Timeout counter: cleared on acceptance, counts every REQ/WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
    end else if (accept_s) begin
      cnt_r <= 16'd0;
    end else if ((state_r == REQ) || (state_r == WAIT)) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Capture the access on acceptance; bus outputs stay stable for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_r        <= 3'b000;
      off_r       <= 2'b00;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      f3_r        <= funct3;
      off_r       <= ALUResult[1:0];
      mem_we_r    <= MemWrite;
      mem_addr_r  <= {ALUResult[31:2], 2'b00};
      mem_be_r    <= byte_enables(funct3, MemWrite, ALUResult[1:0]);
      mem_wdata_r <= store_lanes(funct3, StoreData);
    end else begin
      f3_r        <= f3_r;
      off_r       <= off_r;
      mem_we_r    <= mem_we_r;
      mem_addr_r  <= mem_addr_r;
      mem_be_r    <= mem_be_r;
      mem_wdata_r <= mem_wdata_r;
    end
  end

  // Registered request and completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_r   <= 1'b0;
      done_r      <= 1'b0;
      align_err_r <= 1'b0;
      bus_err_r   <= 1'b0;
    end else begin
      mem_req_r   <= (state_nxt_s == REQ);
      done_r      <= (state_nxt_s == DONE);
      align_err_r <= fault_s;
      bus_err_r   <= bus_err_s;
    end
  end

  // Load result: extended data on rvalid, zero for any other way into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data_r <= 32'h0000_0000;
    end else if (rd_done_s) begin
      load_data_r <= extract_load(f3_r, off_r, mem_rdata);
    end else if (state_nxt_s == DONE) begin
      load_data_r <= 32'h0000_0000;
    end else begin
      load_data_r <= load_data_r;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: bench-driven bus schedule, cycle-accurate expectations from a
// transaction-level timing model, randomized accesses plus pinned directed cases.
module tb_load_store_unit;
  localparam int T = 4;

  logic        clk;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, StoreData;
  logic        Stall, Done, AlignErr, BusError;
  logic [31:0] LoadData;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total, bad;
  logic        chk_en;
  logic        exp_stall, exp_req, exp_done, exp_aerr, exp_berr, exp_we;
  logic [31:0] exp_load, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  int          stall_cnt, req_cnt, done_cnt;
  logic [31:0] last_addr, last_wdata, last_load;
  logic [3:0]  last_be;
  logic        last_aerr, last_berr;
  int          s0, q0, d0;
  logic        rw, rb, nzg, nzr, lrv;
  logic [2:0]  rf3;
  logic [31:0] ra;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .ALUResult(ALUResult), .StoreData(StoreData), .Stall(Stall), .Done(Done),
    .LoadData(LoadData), .AlignErr(AlignErr), .BusError(BusError), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else return 4;
  endfunction

  function automatic bit m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit sup;
    sup = (f3 inside {3'd0, 3'd1, 3'd2}) || (!we && (f3 inside {3'd4, 3'd5}));
    return sup && ((a % acc_size(f3)) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    if (!we) return 4'hF;
    m = 4'((1 << acc_size(f3)) - 1);
    return m << a[1:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (acc_size(f3) == 1) return 32'(d[7:0]) * 32'h0101_0101;
    else if (acc_size(f3) == 2) return 32'(d[15:0]) * 32'h0001_0001;
    else return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] lane, mask, v;
    int sz;
    sz = acc_size(f3);
    if (sz == 4) return rd;
    lane = rd >> (8 * a[1:0]);
    mask = (32'h1 << (8 * sz)) - 32'h1;
    v = lane & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_cycles(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      mem_gnt = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
      exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_aerr = 1'b0; exp_berr = 1'b0;
    end
  endtask

  // One access: g = REQ cycles waited before gnt, r = cycles from gnt to rvalid.
  task automatic run_txn(input logic we, input logic both, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                         input int g, input int r, input logic nz_g, input logic nz_r,
                         input logic late_rv, input int gap);
    bit legal, tmo;
    int dn;
    logic [31:0] eload;
    legal = m_legal(we, f3, a);
    tmo = 1'b0;
    if (!legal) dn = 1;
    else if (we) begin
      if (g <= T - 1) dn = g + 2;
      else begin dn = T + 1; tmo = 1'b1; end
    end else begin
      if (g + 1 + r <= T) dn = g + r + 2;
      else begin dn = T + 1; tmo = 1'b1; end
    end
    eload = (legal && !we && !tmo) ? m_load(f3, a, rd) : 32'h0;
    for (int k = 0; k <= dn; k++) begin
      @(posedge clk); #1;
      MemWrite = (k < dn) && we;
      MemRead = (k < dn) && (!we || both);
      funct3 = f3; ALUResult = a; StoreData = d;
      mem_gnt = legal && ((k == g + 1 && k < dn) || (nz_g && !we && k > g + 1 && k < dn));
      mem_rvalid = (legal && !we && k == g + 1 + r && k <= dn) ||
                   (nz_r && legal && k >= 1 && k <= g + 1 && k < dn) || (late_rv && k == dn);
      mem_rdata = (k == g + 1 + r) ? rd : $urandom;
      exp_stall = (k < dn);
      exp_req = legal && k >= 1 && k <= g + 1 && k < dn;
      exp_done = (k == dn);
      exp_aerr = (k == dn) && !legal;
      exp_berr = (k == dn) && tmo;
      exp_load = eload;
      exp_addr = {a[31:2], 2'b00};
      exp_be = m_be(we, f3, a);
      exp_wdata = m_wdata(f3, d);
      exp_we = we;
    end
    @(negedge clk); #1;
    idle_cycles(gap, 1'b1);
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 1'b0;
    stall_cnt = 0; req_cnt = 0; done_cnt = 0;
    last_addr = '0; last_wdata = '0; last_load = '0; last_be = '0; last_aerr = 1'b0; last_berr = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_aerr = 1'b0; exp_berr = 1'b0;
    exp_we = 1'b0; exp_load = '0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    ALUResult = '0; StoreData = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    fork
      forever begin
        @(negedge clk);
        if (Stall) stall_cnt++;
        if (Done) done_cnt++;
        if (mem_req) begin
          req_cnt++; last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata;
        end
        if (Done) begin
          last_load = LoadData; last_aerr = AlignErr; last_berr = BusError;
        end
        if (chk_en) begin
          chk("stall", 32'(Stall), 32'(exp_stall));
          chk("mem_req", 32'(mem_req), 32'(exp_req));
          chk("done", 32'(Done), 32'(exp_done));
          chk("align_err", 32'(AlignErr), 32'(exp_aerr));
          chk("bus_error", 32'(BusError), 32'(exp_berr));
          if (exp_req) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_be", 32'(mem_be), 32'(exp_be));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
          end
          if (exp_done) chk("load_data", LoadData, exp_load);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(Stall), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_be", 32'(mem_be), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_load", LoadData, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle_cycles(2, 1'b0);

    s0 = stall_cnt;
    run_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 1'b0, 1'b0, 1'b0, 0);
    chk("sw_stall_cycles", 32'(stall_cnt - s0), 32'd2);
    chk("sw_addr", last_addr, 32'h100);
    chk("sw_be", 32'(last_be), 32'hF);
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);

    run_txn(1'b0, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_FF7F, 0, 2, 1'b0, 1'b0, 1'b0, 1);
    chk("lb_be", 32'(last_be), 32'hF);
    chk("lb_data", last_load, 32'hFFFF_FF80);
    run_txn(1'b0, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_FF7F, 0, 2, 1'b0, 1'b0, 1'b0, 0);
    chk("lbu_data", last_load, 32'h0000_0080);

    run_txn(1'b1, 1'b0, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 0, 1, 1'b0, 1'b0, 1'b0, 0);
    chk("sh_addr", last_addr, 32'h20);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCDABCD);

    q0 = req_cnt;
    run_txn(1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 32'h5555_5555, 0, 1, 1'b0, 1'b0, 1'b0, 1);
    chk("lw_mis_req_cycles", 32'(req_cnt - q0), 32'd0);
    chk("lw_mis_align", 32'(last_aerr), 32'd1);
    chk("lw_mis_data", last_load, 32'h0);

    q0 = req_cnt;
    run_txn(1'b0, 1'b0, 3'b010, 32'h300, 32'h0, 32'h1111_2222, 99, 1, 1'b0, 1'b0, 1'b1, 2);
    chk("tmo_req_cycles", 32'(req_cnt - q0), 32'd4);
    chk("tmo_bus_error", 32'(last_berr), 32'd1);
    chk("tmo_align", 32'(last_aerr), 32'd0);

    // Abandon a load in WAIT with an asynchronous reset.
    d0 = done_cnt;
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h40;
    exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_aerr = 1'b0; exp_berr = 1'b0;
    @(posedge clk); #1;
    mem_gnt = 1'b1; exp_req = 1'b1; exp_addr = 32'h40; exp_be = 4'hF; exp_we = 1'b0;
    @(posedge clk); #1;
    mem_gnt = 1'b0; exp_req = 1'b0;
    #1;
    rst_n = 1'b0;
    exp_stall = 1'b0;
    #1;
    chk("rst_async_stall", 32'(Stall), 32'h0);
    chk("rst_async_req", 32'(mem_req), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    MemRead = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    rst_n = 1'b1;
    idle_cycles(3, 1'b1);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    run_txn(1'b1, 1'b0, 3'b000, 32'h31, 32'h0000_005A, 32'h0, 0, 1, 1'b0, 1'b0, 1'b0, 0);
    chk("sb_after_rst_be", 32'(last_be), 32'h2);
    chk("sb_after_rst_wdata", last_wdata, 32'h5A5A5A5A);
    chk("sb_after_rst_done", 32'(done_cnt - d0), 32'd1);

    for (int n = 0; n < 80; n++) begin
      rw = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      ra = $urandom;
      if ($urandom_range(0, 2) == 0) ra[1:0] = 2'b00;
      nzg = 1'($urandom_range(0, 1));
      nzr = 1'($urandom_range(0, 1));
      lrv = 1'($urandom_range(0, 1));
      run_txn(rw, rb, rf3, ra, $urandom, $urandom, $urandom_range(0, 4),
              $urandom_range(1, 3), nzg, nzr, lrv, $urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
